// File: rtl/rr_mux_arbiter_if.sv
// Bundle of the request/data/grant signals between four producers, the arbiter
// and one downstream consumer.
//   master : producer/consumer side, drives req, a..d, y_ready; observes gnt, sel, y, y_valid
//   slave  : arbiter side, the mirror image of master
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             y_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (
    output req, a, b, c, d, y_ready,
    input  gnt, sel, y, y_valid
  );

  modport slave (
    input  req, a, b, c, d, y_ready,
    output gnt, sel, y, y_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters. One requester
// owns the datapath at a time; its data is presented on a valid/ready port and
// each grant is capped at MAX_BURST accepted beats.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave modport carrying req, a..d, y_ready (in) and gnt, sel, y, y_valid (out)
module rr_mux_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4   // legal range 1..255
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_if.slave    bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state, state_n;
  logic [3:0] gnt_r, gnt_n;
  logic [1:0] sel_r, sel_n;
  logic [1:0] ptr_r, ptr_n;
  logic [7:0] cnt_r, cnt_n;

  logic       xfer;
  logic       release_grant;
  logic [1:0] search_ptr;
  logic [2:0] winner;         // {found, index}

  // First requester at or after p, wrapping mod 4. Scanning from the far end
  // down lets the nearest hit overwrite farther ones.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Datapath and handshake are combinational off the registered select, so a
  // non-granted requester can never disturb y.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bus.y_valid = (state == BUSY) && bus.req[sel_r];
    bus.y       = '0;
    if (bus.y_valid) begin
      unique case (sel_r)
        2'd0: bus.y = bus.a;
        2'd1: bus.y = bus.b;
        2'd2: bus.y = bus.c;
        2'd3: bus.y = bus.d;
      endcase
    end
  end

  assign bus.gnt = gnt_r;
  assign bus.sel = sel_r;

  assign xfer          = bus.y_valid && bus.y_ready;
  assign release_grant = (state == BUSY) &&
                         (!bus.req[sel_r] || (xfer && (cnt_r == LAST_BEAT)));
  // On release the outgoing owner drops to lowest priority immediately, so the
  // search for the back-to-back winner already uses the advanced pointer.
  assign search_ptr    = release_grant ? sel_r + 2'd1 : ptr_r;
  assign winner        = pick(bus.req, search_ptr);

  always_comb begin
    state_n = state;
    sel_n   = sel_r;
    ptr_n   = ptr_r;
    cnt_n   = cnt_r;
    unique case (state)
      IDLE: begin
        if (winner[2]) begin
          state_n = BUSY;
          sel_n   = winner[1:0];
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          ptr_n = sel_r + 2'd1;
          cnt_n = '0;
          if (winner[2]) sel_n   = winner[1:0];
          else           state_n = IDLE;
        end else if (xfer) begin
          cnt_n = cnt_r + 8'd1;
        end
      end
    endcase
    gnt_n = (state_n == BUSY) ? (4'b0001 << sel_n) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      gnt_r <= '0;
      sel_r <= '0;
      ptr_r <= '0;
      cnt_r <= '0;
    end else begin
      state <= state_n;
      gnt_r <= gnt_n;
      sel_r <= sel_n;
      ptr_r <= ptr_n;
      cnt_r <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level round-robin model.
module tb_rr_mux_arbiter;
  localparam int W  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(W)) bus ();

  rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: who owns the mux, where the rotation starts, beats so far.
  int owner;      // -1 when nobody holds a grant
  int ptr;
  int beats;
  int last_sel;
  logic [W-1:0] data [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    owner    = -1;
    ptr      = 0;
    beats    = 0;
    last_sel = 0;
  endtask

  // One clock: drive at the falling edge, compare settled outputs, then let
  // the model advance on the same rising edge the DUT sees.
  task automatic cycle(input logic [3:0] r, input logic rdy);
    logic exp_valid;
    logic [W-1:0] exp_y;
    logic [3:0] exp_gnt;
    @(negedge clk);
    bus.req     = r;
    bus.y_ready = rdy;
    bus.a = data[0];
    bus.b = data[1];
    bus.c = data[2];
    bus.d = data[3];
    #1;
    exp_valid = (owner >= 0) && r[owner];
    exp_y     = exp_valid ? data[owner] : '0;
    exp_gnt   = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    check("gnt",     32'(bus.gnt),     32'(exp_gnt));
    check("sel",     32'(bus.sel),     32'(last_sel));
    check("y_valid", 32'(bus.y_valid), 32'(exp_valid));
    check("y",       32'(bus.y),       32'(exp_y));
    @(posedge clk);
    if (owner < 0) begin
      owner = search(r, ptr);
      beats = 0;
    end else begin
      if (!r[owner] || (exp_valid && rdy && beats + 1 == MB)) begin
        ptr   = (owner + 1) % 4;
        beats = 0;
        owner = search(r, ptr);
      end else if (exp_valid && rdy) begin
        beats++;
      end
    end
    if (owner >= 0) last_sel = owner;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    check("rst_y_valid", 32'(bus.y_valid), 32'd0);
    check("rst_y",       32'(bus.y),       32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.y_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    for (int i = 0; i < 4; i++) data[i] = W'(i + 1);
    model_reset();
    #3;
    check("por_gnt",     32'(bus.gnt),     32'd0);
    check("por_sel",     32'(bus.sel),     32'd0);
    check("por_y_valid", 32'(bus.y_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Lone requester 2: 4-beat bursts regranted with no gap.
    data[2] = 4'hA;
    for (int k = 0; k < 12; k++) begin
      cycle(4'b0100, 1'b1);
      if (k >= 1) check("lone_no_gap", 32'(bus.y_valid), 32'd1);
    end

    // Reset mid-burst: grant edge then two beats leave cnt=2.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b1);
    do_reset();
    cycle(4'b1111, 1'b1);          // ptr back to 0 -> requester 0 wins
    cycle(4'b1111, 1'b1);
    check("ptr_after_rst", 32'(bus.gnt), 32'b0001);

    // All requesting: 0,1,2,3,0 each exactly MB beats, back to back.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      cycle(4'b1111, 1'b1);
      if (k >= 1) check("rr_order", 32'(bus.gnt), 32'(4'b0001 << (((k - 1) / MB) % 4)));
    end

    // Stall: grant to 1, y_ready low for 10 cycles, then resume.
    do_reset();
    data[1] = 4'h5;
    cycle(4'b0010, 1'b1);
    cycle(4'b0010, 1'b1);          // one beat taken
    for (int k = 0; k < 10; k++) cycle(4'b0010, 1'b0);
    for (int k = 0; k < 6; k++) cycle(4'b0010, 1'b1);

    // Drop req[1] after two beats: requester 3 takes over.
    do_reset();
    cycle(4'b1010, 1'b1);
    cycle(4'b1010, 1'b1);
    cycle(4'b1010, 1'b1);
    cycle(4'b1000, 1'b1);
    cycle(4'b1000, 1'b1);
    check("drop_handover", 32'(bus.gnt), 32'b1000);

    // Lone requester 0 quits after one beat, then 0011 -> ptr=1 favours 1.
    do_reset();
    cycle(4'b0001, 1'b1);
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    cycle(4'b0011, 1'b1);
    cycle(4'b0011, 1'b1);
    check("ptr_after_idle", 32'(bus.gnt), 32'b0010);

    // Randomized traffic with free-running data changes.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
        r[i]    = ($urandom_range(0, 9) < 7);
        data[i] = W'($urandom);
      end
      cycle(r, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
